mod_counter_bank: RTL and testbench
===================================

Name: mod_counter_bank

Overview:
Parametrised bank of CH independent modulo counters for the clock/calendar datapath, replacing the fixed 3-channel, 3-bit counter.
Each channel has:
- a channel select that clears the channel when low,
- a count enable,
- an up/down direction,
- a synchronous load,
- a runtime terminal value, so one bank can serve 0..59, 0..23, and 28/29/30/31-day month fields.

Per-channel terminal-count outputs are combinational so banks cascade as a same-cycle carry chain. A registered wrap pulse serves downstream display and date logic.

Parameters:
CH, 3, number of counter channels (>=1)
W, 3, counter width per channel in bits (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
sel  input  CH  channel select; 0 = channel held cleared
en  input  CH  count enable per channel
dir  input  CH  1 = count down, 0 = count up
load  input  CH  synchronous load strobe per channel
load_val  input  CH*W  load values; channel i at [i*W +: W]
mod_max  input  CH*W  terminal (maximum) value per channel; channel i at [i*W +: W]
cnt  output  CH*W  counter values; channel i at [i*W +: W]
tc  output  CH  combinational terminal count per channel
tc_any  output  1  OR of tc
wrap  output  CH  registered one-cycle wrap pulse per channel

Behaviour:
- Reset: rst_n low asynchronously forces all cnt to 0 and all wrap to 0. Release is sampled at the next rising clk edge.
- Per-channel update at posedge clk. Priority is highest first:
  1. sel[i]=0: cnt_i <= 0, wrap[i] <= 0.
  2. load[i]=1: cnt_i <= load_val_i if load_val_i <= mod_max_i, else 0. wrap[i] <= 0. Load ignores en.
  3. en[i]=1, dir[i]=0 (up):
     - cnt_i >= mod_max_i: cnt_i <= 0, wrap[i] <= 1.
     - otherwise: cnt_i <= cnt_i + 1, wrap[i] <= 0.
  4. en[i]=1, dir[i]=1 (down):
     - cnt_i == 0: cnt_i <= mod_max_i, wrap[i] <= 1.
     - cnt_i > mod_max_i: cnt_i <= mod_max_i, wrap[i] <= 0.
     - otherwise: cnt_i <= cnt_i - 1, wrap[i] <= 0.
  5. Otherwise: cnt_i holds, wrap[i] <= 0.
- tc[i] = sel[i] & ~load[i] & en[i] & (dir[i] ? cnt_i==0 : cnt_i>=mod_max_i). tc is purely combinational and is asserted in the same cycle as the edge that wraps.
- tc_any = |tc.
- wrap[i] is high for exactly one cycle, the cycle after the wrapping edge.
- mod_max_i=0: up mode holds at 0 and wraps every enabled cycle; down mode behaves the same.
- mod_max = all ones (2^W-1): counter is a plain W-bit binary counter with natural wrap.
- Lowering mod_max below the current cnt:
  - Up mode: the next enabled edge goes to 0 with wrap.
  - Down mode: the next enabled edge clamps to mod_max with no wrap.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Arithmetic is W bits unsigned, with no overflow beyond the rules above.
- rst_n asserted mid-count clears everything immediately, without waiting for clk. A wrap pulse in flight is cancelled.
- Latency: control input to cnt change is 1 clk. tc has zero latency, combinational from cnt and controls.

Test Plan:
1. Reset and idle (CH=3, W=3), all inputs 0: rst_n low mid-cycle -> cnt=0, wrap=0 immediately, tc=0, and outputs hold for 10 clocks after release.
2. Up wrap, ch0 sel=1 en=1 dir=0 mod_max=5 for 8 clocks:
   - cnt0 sequence: 1,2,3,4,5,0,1,2.
   - tc[0]=1 while cnt0=5; tc_any=1 in that cycle.
   - wrap[0]=1 only in the cycle cnt0 first reads 0.
3. Down wrap, ch1 dir=1 mod_max=6 from cnt1=1 for 4 clocks -> cnt1: 0,6,5,4. tc[1]=1 while cnt1=0; wrap[1] pulses when cnt1 becomes 6.
4. Priority on ch2, mod_max=4:
   - sel=0 with load=1 and en=1 -> cnt2=0.
   - Then sel=1, load=1, load_val=7 -> cnt2=0 (clamped).
   - Then load_val=3 -> cnt2=3, with en ignored and tc[2]=0 during load.
5. mod_max change: ch0 up at cnt0=6, mod_max 7->2 -> next enabled edge gives cnt0=0 with wrap[0]=1. Same in down mode from cnt0=6 -> cnt0=2, wrap[0]=0.
6. Full-range and independence, W=3, mod_max=7 on all channels:
   - ch0 counts up, ch1 counts down, ch2 is disabled.
   - After 8 clocks: ch0=0, ch1=0, ch2 unchanged.
   - wrap[0] and wrap[1] each pulse once, and no cross-channel effects occur.

Source files
------------

// File: rtl/mod_counter_bank.sv
// mod_counter_bank: bank of CH independent up/down modulo counters with runtime terminal values
// Combinational tc feeds same-cycle cascades; wrap is the registered one-cycle version of tc.
module mod_counter_bank #(
  parameter int CH = 3,
  parameter int W  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   sel,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   dir,
  input  logic [CH-1:0]   load,
  input  logic [CH*W-1:0] load_val,
  input  logic [CH*W-1:0] mod_max,
  output logic [CH*W-1:0] cnt,
  output logic [CH-1:0]   tc,
  output logic            tc_any,
  output logic [CH-1:0]   wrap
);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] q, mx, lv, nxt;
    logic w, at_top, at_zero;
    assign mx      = mod_max[i*W +: W];
    assign lv      = load_val[i*W +: W];
    assign at_top  = q >= mx;
    assign at_zero = q == '0;
    assign tc[i]   = sel[i] & ~load[i] & en[i] & (dir[i] ? at_zero : at_top);
    // a count above a lowered terminal clamps to it when counting down
    always_comb begin
      nxt = !sel[i] ? '0 :
            load[i] ? (lv <= mx ? lv : '0) :
            !en[i]  ? q :
            dir[i]  ? ((at_zero || q > mx) ? mx : q - W'(1)) :
                      (at_top ? '0 : q + W'(1));
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
        w <= 1'b0;
      end else begin
        q <= nxt;
        w <= tc[i];
      end
    end
    assign cnt[i*W +: W] = q;
    assign wrap[i]       = w;
  end
  assign tc_any = |tc;
endmodule

// File: tb/tb_mod_counter_bank.sv
// tb_mod_counter_bank: scoreboard bench for mod_counter_bank
module tb_mod_counter_bank;
  localparam int CH = 3;
  localparam int W  = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0] sel = '0, en = '0, dir = '0, load = '0;
  logic [CH*W-1:0] load_val = '0, mod_max = '0;
  logic [CH*W-1:0] cnt;
  logic [CH-1:0] tc, wrap;
  logic tc_any;
  typedef struct packed {
    logic [CH*W-1:0] c;
    logic [CH-1:0]   w;
  } exp_t;
  exp_t sb[$];
  int mc[CH];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mod_counter_bank #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .mod_max(mod_max), .cnt(cnt), .tc(tc), .tc_any(tc_any), .wrap(wrap)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int cnt_of(input int i);
    return int'(cnt[i*W +: W]);
  endfunction
  task automatic set_ch(input int i, input bit s, input bit e, input bit d, input bit l, input int lv, input int mx);
    sel[i] = s; en[i] = e; dir[i] = d; load[i] = l;
    load_val[i*W +: W] = W'(lv);
    mod_max[i*W +: W]  = W'(mx);
  endtask
  // model one edge from the current inputs, check tc now, queue the post-edge result
  task automatic step(input string tag);
    exp_t e;
    logic [CH-1:0] et;
    e = '0;
    et = '0;
    #1;
    for (int i = 0; i < CH; i++) begin
      int c, m, lv, nc;
      bit t;
      c = mc[i]; m = int'(mod_max[i*W +: W]); lv = int'(load_val[i*W +: W]); t = 0;
      if (!sel[i]) nc = 0;
      else if (load[i]) nc = (lv <= m) ? lv : 0;
      else if (!en[i]) nc = c;
      else if (!dir[i]) begin
        if (c >= m) begin nc = 0; t = 1; end
        else nc = c + 1;
      end else begin
        if (c == 0) begin nc = m; t = 1; end
        else if (c > m) nc = m;
        else nc = c - 1;
      end
      et[i] = t;
      e.w[i] = t;
      e.c[i*W +: W] = W'(nc);
      mc[i] = nc;
    end
    check({tag, "/tc"}, 32'(tc), 32'(et));
    check({tag, "/tc_any"}, 32'(tc_any), 32'(|et));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check({tag, "/sb_empty"}, 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      check({tag, "/cnt"}, 32'(cnt), 32'(e.c));
      check({tag, "/wrap"}, 32'(wrap), 32'(e.w));
    end
  endtask
  initial begin
    int seq2[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int seq3[4] = '{0, 6, 5, 4};
    int nw0, nw1, nw2;
    foreach (mc[i]) mc[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cnt", 32'(cnt), 32'd0);
    check("reset_wrap", 32'(wrap), 32'd0);
    check("reset_tc", 32'(tc), 32'd0);
    #3 rst_n = 1'b1;
    // get a nonzero count on ch1 and a wrap in flight on ch0 (mod_max 0)
    set_ch(0, 1, 1, 0, 0, 0, 0);
    set_ch(1, 1, 1, 0, 0, 0, 7);
    repeat (3) step("pre");
    check("pre_wrap0", 32'(wrap[0]), 32'd1);
    check("pre_cnt1", 32'(cnt_of(1)), 32'd3);
    sel = '0; en = '0; dir = '0; load = '0; load_val = '0; mod_max = '0;
    #2 rst_n = 1'b0;
    #1;
    check("async_cnt", 32'(cnt), 32'd0);
    check("async_wrap", 32'(wrap), 32'd0);
    check("async_tc", 32'(tc), 32'd0);
    foreach (mc[i]) mc[i] = 0;
    #2 rst_n = 1'b1;
    repeat (10) step("idle");
    check("idle_cnt", 32'(cnt), 32'd0);
    // up wrap, ch0, mod_max 5
    set_ch(0, 1, 1, 0, 0, 0, 5);
    nw0 = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("up_tc0", 32'(tc[0]), 32'(cnt_of(0) == 5));
      step("up");
      check("up_seq", 32'(cnt_of(0)), 32'(seq2[k]));
      check("up_wrap0", 32'(wrap[0]), 32'(k == 5));
      nw0 += int'(wrap[0]);
    end
    check("up_nwrap", 32'(nw0), 32'd1);
    set_ch(0, 1, 0, 0, 0, 0, 5);
    // down wrap, ch1 from 1, mod_max 6
    set_ch(1, 1, 0, 1, 1, 1, 6);
    step("ld1");
    check("ld1_cnt1", 32'(cnt_of(1)), 32'd1);
    set_ch(1, 1, 1, 1, 0, 0, 6);
    for (int k = 0; k < 4; k++) begin
      step("down");
      check("down_seq", 32'(cnt_of(1)), 32'(seq3[k]));
      check("down_wrap1", 32'(wrap[1]), 32'(k == 1));
    end
    set_ch(1, 1, 0, 1, 0, 0, 6);
    // priority on ch2; dir down at cnt 0 would raise tc if load were not masking it
    set_ch(2, 0, 1, 1, 1, 3, 4);
    step("pri_sel");
    check("pri_sel_cnt2", 32'(cnt_of(2)), 32'd0);
    set_ch(2, 1, 1, 1, 1, 7, 4);
    #1 check("pri_ld_tc2", 32'(tc[2]), 32'd0);
    step("pri_clamp");
    check("pri_clamp_cnt2", 32'(cnt_of(2)), 32'd0);
    set_ch(2, 1, 1, 1, 1, 3, 4);
    step("pri_ld3");
    check("pri_ld3_cnt2", 32'(cnt_of(2)), 32'd3);
    set_ch(2, 1, 0, 0, 0, 0, 4);
    // lowered mod_max, up then down
    set_ch(0, 1, 0, 0, 1, 6, 7);
    step("mm_ld");
    set_ch(0, 1, 1, 0, 0, 0, 2);
    step("mm_up");
    check("mm_up_cnt0", 32'(cnt_of(0)), 32'd0);
    check("mm_up_wrap0", 32'(wrap[0]), 32'd1);
    set_ch(0, 1, 0, 1, 1, 6, 7);
    step("mm_ld2");
    set_ch(0, 1, 1, 1, 0, 0, 2);
    step("mm_dn");
    check("mm_dn_cnt0", 32'(cnt_of(0)), 32'd2);
    check("mm_dn_wrap0", 32'(wrap[0]), 32'd0);
    // full range and independence
    set_ch(0, 1, 0, 0, 1, 0, 7);
    set_ch(1, 1, 0, 1, 1, 0, 7);
    set_ch(2, 1, 0, 0, 1, 5, 7);
    step("fr_ld");
    set_ch(0, 1, 1, 0, 0, 0, 7);
    set_ch(1, 1, 1, 1, 0, 0, 7);
    set_ch(2, 1, 0, 0, 0, 0, 7);
    nw0 = 0; nw1 = 0; nw2 = 0;
    repeat (8) begin
      step("fr");
      nw0 += int'(wrap[0]); nw1 += int'(wrap[1]); nw2 += int'(wrap[2]);
    end
    check("fr_cnt0", 32'(cnt_of(0)), 32'd0);
    check("fr_cnt1", 32'(cnt_of(1)), 32'd0);
    check("fr_cnt2", 32'(cnt_of(2)), 32'd5);
    check("fr_nwrap0", 32'(nw0), 32'd1);
    check("fr_nwrap1", 32'(nw1), 32'd1);
    check("fr_nwrap2", 32'(nw2), 32'd0);
    // random mix, mod_max often small or zero
    repeat (200) begin
      for (int i = 0; i < CH; i++)
        set_ch(i, $urandom_range(7) != 0, $urandom_range(3) != 0, $urandom_range(1),
               $urandom_range(7) == 0, $urandom_range(7),
               ($urandom_range(3) == 0) ? 0 : $urandom_range(7));
      step("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
